// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Provides stage indices into the per-stage valid vector, the register address
// width, the default stall counter width and the source/destination compare helper.
package pipe_ctrl_pkg;

    localparam int unsigned NumStages   = 5;
    localparam int unsigned StageIf     = 0;
    localparam int unsigned StageId     = 1;
    localparam int unsigned StageEx     = 2;
    localparam int unsigned StageMem    = 3;
    localparam int unsigned StageWb     = 4;

    localparam int unsigned RegAddrBusW = 5;
    localparam int unsigned CntWDefault = 32;

    typedef logic [RegAddrBusW-1:0] reg_addr_t;

    // A source only matches a destination that belongs to a live instruction.
    function automatic logic src_match(reg_addr_t src, reg_addr_t dest, logic dest_valid);
        return (src == dest) & dest_valid;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath stages and the pipeline sequencer.
// slave  : the sequencer side (takes stage status and ID operands, drives valids,
//          bus latch enables, fetch advance, hazard flag and stall count).
// master : the datapath side (the mirror image).
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = pipe_ctrl_pkg::CntWDefault
);
    import pipe_ctrl_pkg::*;

    // Stage status and operands from the datapath
    logic       ctl_if_over_i;
    logic       ctl_id_over_i;
    logic       ctl_ex_over_i;
    logic       ctl_mem_over_i;
    logic       ctl_wb_over_i;
    reg_addr_t  ctl_ex_dest_i;
    reg_addr_t  ctl_mem_dest_i;
    reg_addr_t  ctl_wb_dest_i;
    reg_addr_t  id_rs_i;
    reg_addr_t  id_rt_i;
    logic       id_rs_used_i;
    logic       id_rt_used_i;
    logic       flush_i;

    // Control back to the datapath
    logic             ctl_if_valid_o;
    logic             ctl_id_valid_o;
    logic             ctl_ex_valid_o;
    logic             ctl_mem_valid_o;
    logic             ctl_wb_valid_o;
    logic             ctl_id_latch_o;
    logic             ctl_ex_latch_o;
    logic             ctl_mem_latch_o;
    logic             ctl_wb_latch_o;
    logic             next_fetch_o;
    logic             hazard_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  ctl_if_over_i, ctl_id_over_i, ctl_ex_over_i, ctl_mem_over_i, ctl_wb_over_i,
        input  ctl_ex_dest_i, ctl_mem_dest_i, ctl_wb_dest_i,
        input  id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, flush_i,
        output ctl_if_valid_o, ctl_id_valid_o, ctl_ex_valid_o, ctl_mem_valid_o, ctl_wb_valid_o,
        output ctl_id_latch_o, ctl_ex_latch_o, ctl_mem_latch_o, ctl_wb_latch_o,
        output next_fetch_o, hazard_o, stall_cnt_o
    );

    modport master (
        output ctl_if_over_i, ctl_id_over_i, ctl_ex_over_i, ctl_mem_over_i, ctl_wb_over_i,
        output ctl_ex_dest_i, ctl_mem_dest_i, ctl_wb_dest_i,
        output id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, flush_i,
        input  ctl_if_valid_o, ctl_id_valid_o, ctl_ex_valid_o, ctl_mem_valid_o, ctl_wb_valid_o,
        input  ctl_id_latch_o, ctl_ex_latch_o, ctl_mem_latch_o, ctl_wb_latch_o,
        input  next_fetch_o, hazard_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write hazard compare for the ID stage.
// Ports:
//   id_valid            ID holds a live instruction
//   id_rs / id_rt       ID source register addresses
//   id_rs_used/rt_used  ID instruction actually reads that source
//   ex/mem/wb_valid     valid register of each producing stage
//   ex/mem/wb_dest      destination address presented by each producing stage
//   hazard              ID must stall (purely combinational)
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit HAZARD_WB = 1'b1
) (
    input  logic      id_valid,
    input  reg_addr_t id_rs,
    input  reg_addr_t id_rt,
    input  logic      id_rs_used,
    input  logic      id_rt_used,
    input  logic      ex_valid,
    input  logic      mem_valid,
    input  logic      wb_valid,
    input  reg_addr_t ex_dest,
    input  reg_addr_t mem_dest,
    input  reg_addr_t wb_dest,
    output logic      hazard
);

    logic wb_check;
    logic rs_hit;
    logic rt_hit;

    // WB only matters when the register file cannot forward a same-cycle write.
    assign wb_check = HAZARD_WB & wb_valid;

    // r0 is hardwired to zero, so it never carries a dependency.
    assign rs_hit = id_rs_used & (id_rs != '0) &
                    (src_match(id_rs, ex_dest, ex_valid) |
                     src_match(id_rs, mem_dest, mem_valid) |
                     src_match(id_rs, wb_dest, wb_check));

    assign rt_hit = id_rt_used & (id_rt != '0) &
                    (src_match(id_rt, ex_dest, ex_valid) |
                     src_match(id_rt, mem_dest, mem_valid) |
                     src_match(id_rt, wb_dest, wb_check));

    assign hazard = id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
// Owns the stage valid registers, the allow-in chain and the bus latch enables,
// stalls ID on RAW hazards, kills IF/ID on a taken branch and counts stall cycles.
// Ports:
//   clk   core clock
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_if.slave: stage over flags, producer destinations, ID sources,
//         flush in; stage valids, latch enables, next_fetch, hazard, stall count out
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit          HAZARD_WB = 1'b1,
    parameter int unsigned CNT_W     = CntWDefault
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [NumStages-1:0] valid_q;
    logic [NumStages-1:0] valid_d;
    logic                 start_q;
    logic                 start_pulse;
    logic [CNT_W-1:0]     stall_cnt_q;

    logic hazard;
    logic hazard_out;
    logic wb_allowin, mem_allowin, ex_allowin, id_allowin, if_allowin;
    logic if_to_id, id_to_ex, ex_to_mem, mem_to_wb;

    hazard_detect #(
        .HAZARD_WB (HAZARD_WB)
    ) u_hazard_detect (
        .id_valid   (valid_q[StageId]),
        .id_rs      (bus.id_rs_i),
        .id_rt      (bus.id_rt_i),
        .id_rs_used (bus.id_rs_used_i),
        .id_rt_used (bus.id_rt_used_i),
        .ex_valid   (valid_q[StageEx]),
        .mem_valid  (valid_q[StageMem]),
        .wb_valid   (valid_q[StageWb]),
        .ex_dest    (bus.ctl_ex_dest_i),
        .mem_dest   (bus.ctl_mem_dest_i),
        .wb_dest    (bus.ctl_wb_dest_i),
        .hazard     (hazard)
    );

    // Allow-in ripples back from WB so a stage can accept in the same cycle its
    // occupant leaves.
    assign wb_allowin  = !valid_q[StageWb]  | bus.ctl_wb_over_i;
    assign mem_allowin = !valid_q[StageMem] | (bus.ctl_mem_over_i & wb_allowin);
    assign ex_allowin  = !valid_q[StageEx]  | (bus.ctl_ex_over_i & mem_allowin);
    assign id_allowin  = !valid_q[StageId]  | (bus.ctl_id_over_i & !hazard & ex_allowin);
    assign if_allowin  = !valid_q[StageIf]  | (bus.ctl_if_over_i & id_allowin);

    assign mem_to_wb = valid_q[StageMem] & bus.ctl_mem_over_i & wb_allowin;
    assign ex_to_mem = valid_q[StageEx] & bus.ctl_ex_over_i & mem_allowin;
    assign id_to_ex  = valid_q[StageId] & bus.ctl_id_over_i & !hazard & ex_allowin &
                       !bus.flush_i;
    assign if_to_id  = valid_q[StageIf] & bus.ctl_if_over_i & id_allowin & !bus.flush_i;

    // Gated by rst so nothing asks for a fetch while reset is held.
    assign start_pulse = !start_q & !rst;
    assign hazard_out  = hazard & !bus.flush_i;

    always_comb begin
        valid_d = valid_q;
        if (wb_allowin)  valid_d[StageWb]  = mem_to_wb;
        if (mem_allowin) valid_d[StageMem] = ex_to_mem;
        if (ex_allowin)  valid_d[StageEx]  = id_to_ex;
        // The branch in EX kills both younger wrong-path instructions.
        if (bus.flush_i) begin
            valid_d[StageId] = 1'b0;
        end else if (id_allowin) begin
            valid_d[StageId] = if_to_id;
        end
        // A flush also starts the redirected fetch, valid next cycle.
        if (!start_q || bus.flush_i || if_allowin) begin
            valid_d[StageIf] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            start_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            start_q <= 1'b1;
            if (hazard_out) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
        end
    end

    assign bus.ctl_if_valid_o  = valid_q[StageIf];
    assign bus.ctl_id_valid_o  = valid_q[StageId];
    assign bus.ctl_ex_valid_o  = valid_q[StageEx];
    assign bus.ctl_mem_valid_o = valid_q[StageMem];
    assign bus.ctl_wb_valid_o  = valid_q[StageWb];
    assign bus.ctl_id_latch_o  = if_to_id;
    assign bus.ctl_ex_latch_o  = id_to_ex;
    assign bus.ctl_mem_latch_o = ex_to_mem;
    assign bus.ctl_wb_latch_o  = mem_to_wb;
    assign bus.next_fetch_o    = if_to_id | bus.flush_i | start_pulse;
    assign bus.hazard_o        = hazard_out;
    assign bus.stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances share one stimulus stream, one comparing against
// WB (32-bit counter) and one ignoring WB (4-bit counter, so wrap is reachable).
// A slot-occupancy model of the pipeline predicts every output each cycle.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] over;  // bit 0 = IF ... bit 4 = WB
    logic [4:0] ex_dest, mem_dest, wb_dest, rs, rt;
    logic       rs_used, rt_used, flush;

    int n_checks = 0;
    int n_fails  = 0;

    pipe_ctrl_if #(.CNT_W(32)) bus_a ();
    pipe_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.ctl_if_over_i  = over[0];
    assign bus_a.ctl_id_over_i  = over[1];
    assign bus_a.ctl_ex_over_i  = over[2];
    assign bus_a.ctl_mem_over_i = over[3];
    assign bus_a.ctl_wb_over_i  = over[4];
    assign bus_a.ctl_ex_dest_i  = ex_dest;
    assign bus_a.ctl_mem_dest_i = mem_dest;
    assign bus_a.ctl_wb_dest_i  = wb_dest;
    assign bus_a.id_rs_i        = rs;
    assign bus_a.id_rt_i        = rt;
    assign bus_a.id_rs_used_i   = rs_used;
    assign bus_a.id_rt_used_i   = rt_used;
    assign bus_a.flush_i        = flush;
    assign bus_b.ctl_if_over_i  = over[0];
    assign bus_b.ctl_id_over_i  = over[1];
    assign bus_b.ctl_ex_over_i  = over[2];
    assign bus_b.ctl_mem_over_i = over[3];
    assign bus_b.ctl_wb_over_i  = over[4];
    assign bus_b.ctl_ex_dest_i  = ex_dest;
    assign bus_b.ctl_mem_dest_i = mem_dest;
    assign bus_b.ctl_wb_dest_i  = wb_dest;
    assign bus_b.id_rs_i        = rs;
    assign bus_b.id_rt_i        = rt;
    assign bus_b.id_rs_used_i   = rs_used;
    assign bus_b.id_rt_used_i   = rt_used;
    assign bus_b.flush_i        = flush;

    pipe_ctrl #(.HAZARD_WB(1'b1), .CNT_W(32)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pipe_ctrl #(.HAZARD_WB(1'b0), .CNT_W(4))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // {if,id,ex,mem,wb valid, id,ex,mem,wb latch, next_fetch, hazard}
    logic [10:0] obs_a, obs_b;
    logic [21:0] obs;
    logic [35:0] cnt_obs;
    assign obs_a = {bus_a.ctl_if_valid_o, bus_a.ctl_id_valid_o, bus_a.ctl_ex_valid_o,
                    bus_a.ctl_mem_valid_o, bus_a.ctl_wb_valid_o, bus_a.ctl_id_latch_o,
                    bus_a.ctl_ex_latch_o, bus_a.ctl_mem_latch_o, bus_a.ctl_wb_latch_o,
                    bus_a.next_fetch_o, bus_a.hazard_o};
    assign obs_b = {bus_b.ctl_if_valid_o, bus_b.ctl_id_valid_o, bus_b.ctl_ex_valid_o,
                    bus_b.ctl_mem_valid_o, bus_b.ctl_wb_valid_o, bus_b.ctl_id_latch_o,
                    bus_b.ctl_ex_latch_o, bus_b.ctl_mem_latch_o, bus_b.ctl_wb_latch_o,
                    bus_b.next_fetch_o, bus_b.hazard_o};
    assign obs     = {obs_a, obs_b};
    assign cnt_obs = {bus_a.stall_cnt_o, bus_b.stall_cnt_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: which pipeline slots hold an instruction.
    bit [4:0]          m_occ[2], n_occ[2];
    bit                m_start[2], n_start[2];
    longint unsigned   m_cnt[2], n_cnt[2];
    logic [10:0]       e_obs[2];
    logic [21:0]       exp_obs;
    logic [35:0]       exp_cnt;

    function automatic bit hit(logic [4:0] src, logic used, bit [4:0] occ, bit hwb);
        return used && (src != 0) && ((occ[2] && src == ex_dest) ||
               (occ[3] && src == mem_dest) || (hwb && occ[4] && src == wb_dest));
    endfunction

    task automatic model_eval(input int d, input bit hwb, input longint unsigned mask);
        bit [4:0] occ, nocc, lat;
        bit haz, hz, nf, blocked;
        occ  = m_occ[d];
        haz  = occ[1] && (hit(rs, rs_used, occ, hwb) || hit(rt, rt_used, occ, hwb));
        nocc = occ;
        lat  = '0;
        if (occ[4] && over[4]) nocc[4] = 1'b0;
        // Walk from the oldest stage so a slot freed this cycle can be refilled.
        for (int s = 3; s >= 0; s--) begin
            blocked = (s == 1 && haz) || (s <= 1 && flush);
            if (occ[s] && over[s] && !nocc[s+1] && !blocked) begin
                nocc[s+1] = 1'b1;
                nocc[s]   = 1'b0;
                lat[s+1]  = 1'b1;
            end
        end
        if (flush) nocc[1] = 1'b0;
        nocc[0] = 1'b1;  // a fetch is always in flight once running
        nf = lat[1] || flush || (!m_start[d] && !rst);
        hz = haz && !flush;
        e_obs[d] = {occ[0], occ[1], occ[2], occ[3], occ[4], lat[1], lat[2], lat[3], lat[4],
                    nf, hz};
        if (rst) begin
            n_occ[d] = '0; n_start[d] = 1'b0; n_cnt[d] = 0;
        end else begin
            n_occ[d] = nocc; n_start[d] = 1'b1; n_cnt[d] = (m_cnt[d] + 64'(hz)) & mask;
        end
    endtask

    task automatic neg();
        @(negedge clk);
        model_eval(0, 1'b1, 64'hFFFF_FFFF);
        model_eval(1, 1'b0, 64'hF);
        exp_obs = {e_obs[0], e_obs[1]};
        exp_cnt = {m_cnt[0][31:0], m_cnt[1][3:0]};
    endtask

    task automatic pos();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_occ[d] = n_occ[d]; m_start[d] = n_start[d]; m_cnt[d] = n_cnt[d];
        end
        #1;
    endtask

    task automatic set_idle();
        over = 5'h1f; ex_dest = 0; mem_dest = 0; wb_dest = 0; rs = 0; rt = 0;
        rs_used = 0; rt_used = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) begin neg(); pos(); end
        neg();
        n_checks++;
        if (obs !== 22'd0) begin
            n_fails++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_checks++;
        if (cnt_obs !== 36'd0) begin
            n_fails++; $display("FAIL reset_count: got %h want 0", cnt_obs);
        end
        pos();
    endtask

    task automatic test_fill();
        logic [4:0] exp_v;
        rst = 1'b0;
        set_idle();
        for (int k = 1; k <= 6; k++) begin
            neg();
            exp_v = 5'h1f & ~(5'h1f >> (k - 1));
            n_checks++;
            if (obs !== exp_obs) begin
                n_fails++; $display("FAIL fill_model: got %h want %h", obs, exp_obs);
            end
            n_checks++;
            if (obs_a[10:6] !== exp_v || obs_a[1] !== 1'b1 || cnt_obs !== 36'd0) begin
                n_fails++;
                $display("FAIL fill_valids: got v=%b nf=%b cnt=%h want v=%b nf=1 cnt=0",
                         obs_a[10:6], obs_a[1], cnt_obs, exp_v);
            end
            pos();
        end
    endtask

    task automatic test_raw_stall();
        logic [4:0] exd[6] = '{5, 0, 0, 0, 0, 0};
        logic [4:0] md[6]  = '{7, 5, 0, 0, 0, 0};
        logic [4:0] wd[6]  = '{9, 7, 5, 0, 0, 0};
        set_idle();
        rs = 5; rs_used = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ex_dest = exd[c]; mem_dest = md[c]; wb_dest = wd[c];
            neg();
            n_checks++;
            if (obs !== exp_obs || cnt_obs !== exp_cnt) begin
                n_fails++;
                $display("FAIL raw_model: got %h/%h want %h/%h", obs, cnt_obs, exp_obs, exp_cnt);
            end
            if (c < 2) begin
                n_checks++;
                if ({obs_a[0], obs_b[0]} !== 2'b11) begin
                    n_fails++; $display("FAIL raw_hazard: got %b want 11", {obs_a[0], obs_b[0]});
                end
            end
            if (c == 1) begin
                n_checks++;
                if (obs_a[9:8] !== 2'b10) begin
                    n_fails++; $display("FAIL raw_id_held: got id/ex=%b want 10", obs_a[9:8]);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({obs_a[0], obs_b[0]} !== 2'b10) begin
                    n_fails++; $display("FAIL raw_wb_only: got %b want 10", {obs_a[0], obs_b[0]});
                end
            end
            pos();
        end
        set_idle();
        neg();
        n_checks++;
        if (bus_a.stall_cnt_o !== 32'd3 || bus_b.stall_cnt_o !== 4'd2) begin
            n_fails++;
            $display("FAIL raw_stall_count: got %0d/%0d want 3/2", bus_a.stall_cnt_o,
                     bus_b.stall_cnt_o);
        end
        pos();
    endtask

    task automatic test_reg_zero();
        set_idle();
        repeat (5) begin neg(); pos(); end
        rt = 0; rt_used = 1'b1;
        for (int c = 0; c < 3; c++) begin
            neg();
            n_checks++;
            if ({obs_a[9], obs_a[0], obs_b[0]} !== 3'b100 || obs !== exp_obs) begin
                n_fails++;
                $display("FAIL reg_zero: got id=%b haz=%b%b want id=1 haz=00", obs_a[9],
                         obs_a[0], obs_b[0]);
            end
            pos();
        end
    endtask

    task automatic test_ex_busy();
        set_idle();
        repeat (5) begin neg(); pos(); end
        over[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            neg();
            n_checks++;
            if (obs !== exp_obs) begin
                n_fails++; $display("FAIL busy_model: got %h want %h", obs, exp_obs);
            end
            n_checks++;
            if (obs_a[4] !== 1'b0 || obs_a[10:8] !== 3'b111 || (k >= 1 && obs_a[7] !== 1'b0)) begin
                n_fails++;
                $display("FAIL busy_hold: got ex_latch=%b v=%b mem=%b want 0/111/%0d",
                         obs_a[4], obs_a[10:8], obs_a[7], (k == 0));
            end
            pos();
        end
        over = 5'h1f;
        neg();
        n_checks++;
        if (obs_a[5:4] !== 2'b11 || obs !== exp_obs) begin
            n_fails++; $display("FAIL busy_resume: got latches=%b want 11", obs_a[5:4]);
        end
        pos();
    endtask

    task automatic test_flush_hazard();
        set_idle();
        repeat (5) begin neg(); pos(); end
        ex_dest = 5; rs = 5; rs_used = 1'b1; flush = 1'b1;
        neg();
        n_checks++;
        if ({obs_a[9], obs_a[0], obs_a[4], obs_a[3]} !== 4'b1001 || obs !== exp_obs) begin
            n_fails++;
            $display("FAIL flush_cycle: got id/haz/ex_l/mem_l=%b want 1001",
                     {obs_a[9], obs_a[0], obs_a[4], obs_a[3]});
        end
        pos();
        set_idle();
        neg();
        n_checks++;
        if ({obs_a[10], obs_a[9], obs_a[7]} !== 3'b101 || obs !== exp_obs) begin
            n_fails++;
            $display("FAIL flush_after: got if/id/mem=%b want 101", {obs_a[10], obs_a[9], obs_a[7]});
        end
        pos();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 5; s++) over[s] = ($urandom_range(0, 3) != 0);
            ex_dest  = 5'($urandom_range(0, 3));
            mem_dest = 5'($urandom_range(0, 3));
            wb_dest  = 5'($urandom_range(0, 3));
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            rs_used  = 1'($urandom_range(0, 1));
            rt_used  = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 9) == 0);
            neg();
            n_checks++;
            if (obs !== exp_obs || cnt_obs !== exp_cnt) begin
                n_fails++;
                $display("FAIL random_c%0d: got %h/%h want %h/%h", c, obs, cnt_obs, exp_obs,
                         exp_cnt);
            end
            pos();
        end
    endtask

    task automatic test_wrap_reset();
        int i;
        set_idle();
        repeat (6) begin neg(); pos(); end
        over[2] = 1'b0; ex_dest = 5; rs = 5; rs_used = 1'b1;
        i = 0;
        while (m_cnt[1] != 15 && i < 40) begin
            neg();
            n_checks++;
            if (obs !== exp_obs || cnt_obs !== exp_cnt) begin
                n_fails++;
                $display("FAIL wrap_model: got %h/%h want %h/%h", obs, cnt_obs, exp_obs, exp_cnt);
            end
            pos();
            i++;
        end
        neg();
        n_checks++;
        if (cnt_obs[3:0] !== 4'hF || obs_b[0] !== 1'b1) begin
            n_fails++; $display("FAIL wrap_top: got cnt=%h haz=%b want F/1", cnt_obs[3:0], obs_b[0]);
        end
        pos();
        neg();
        n_checks++;
        if (cnt_obs[3:0] !== 4'h0 || cnt_obs !== exp_cnt) begin
            n_fails++; $display("FAIL wrap_zero: got cnt=%h want 0", cnt_obs[3:0]);
        end
        pos();
        rst = 1'b1;
        neg();
        pos();
        neg();
        n_checks++;
        if (obs !== 22'd0 || cnt_obs !== 36'd0) begin
            n_fails++; $display("FAIL midreset: got %h/%h want 0/0", obs, cnt_obs);
        end
        pos();
        rst = 1'b0;
        set_idle();
        neg();
        n_checks++;
        if (obs_a[10] !== 1'b0 || obs_a[1] !== 1'b1 || obs !== exp_obs) begin
            n_fails++; $display("FAIL restart_fetch: got if=%b nf=%b want 0/1", obs_a[10], obs_a[1]);
        end
        pos();
        neg();
        n_checks++;
        if (obs_a[10] !== 1'b1) begin
            n_fails++; $display("FAIL restart_if: got if=%b want 1", obs_a[10]);
        end
        pos();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_occ[d] = '0; m_start[d] = 1'b0; m_cnt[d] = 0;
            n_occ[d] = '0; n_start[d] = 1'b0; n_cnt[d] = 0;
        end
        test_reset();
        test_fill();
        test_raw_stall();
        test_reg_zero();
        test_ex_busy();
        test_flush_hazard();
        test_random();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
